// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external simple dual-port RAM with a 1-cycle synchronous read.
// Define RAM_FIFO_CTRL_ALMOST_FLAGS_EN to add the o_almost_full / o_almost_empty outputs.
module ram_fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AF_LEVEL   = 2**ADDR_WIDTH - 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_valid,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ready,
    input  logic                  i_rd_en,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow,
`ifdef RAM_FIFO_CTRL_ALMOST_FLAGS_EN
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
`endif
    output logic [DATA_WIDTH-1:0] o_ram_dina,
    output logic [ADDR_WIDTH-1:0] o_ram_addra,
    output logic                  o_ram_ena,
    output logic                  o_ram_wea,
    output logic [DATA_WIDTH-1:0] o_ram_dinb,
    output logic [ADDR_WIDTH-1:0] o_ram_addrb,
    output logic                  o_ram_enb,
    output logic                  o_ram_web,
    input  logic [DATA_WIDTH-1:0] i_ram_doutb
);

    localparam int unsigned DEPTH   = 2**ADDR_WIDTH;
    localparam int unsigned CNT_W   = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  rd_valid;
    logic                  overflow;
    logic                  underflow;
    logic                  wr_acc;
    logic                  rd_acc;

    // Status flags are decoded from the registered occupancy only.
    always_comb begin
        o_count     = count;
        o_empty     = (count == CNT_W'(0));
        o_full      = (count == CNT_W'(DEPTH));
        o_wr_ready  = !o_full;
        o_rd_valid  = rd_valid;
        o_overflow  = overflow;
        o_underflow = underflow;
    end

    // Reset gates acceptance so no RAM enable can fire while held in reset.
    always_comb begin
        wr_acc = i_rst_n && i_wr_valid && !o_full;
        rd_acc = i_rst_n && i_rd_en && !o_empty;
    end

    always_comb begin
        o_ram_ena   = wr_acc;
        o_ram_wea   = wr_acc;
        o_ram_addra = wr_ptr;
        o_ram_dina  = i_wr_data;
        o_ram_enb   = rd_acc;
        o_ram_addrb = rd_ptr;
        o_ram_web   = 1'b0;
        o_ram_dinb  = '0;
    end

    // RAM output is only presented while a popped word is valid.
    always_comb begin
        o_rd_data = rd_valid ? i_ram_doutb : '0;
    end

`ifdef RAM_FIFO_CTRL_ALMOST_FLAGS_EN
    always_comb begin
        o_almost_full  = (count >= CNT_W'(AF_LEVEL));
        o_almost_empty = (count <= CNT_W'(1));
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            if (wr_acc && !rd_acc) begin
                count <= count + CNT_W'(1);
            end else if (rd_acc && !wr_acc) begin
                count <= count - CNT_W'(1);
            end
            rd_valid  <= rd_acc;
            overflow  <= i_wr_valid && o_full;
            underflow <= i_rd_en && o_empty;
        end
    end

endmodule
